// File: rtl/shop_pkg.sv
// Shared types and constants for the shop wallet controller slice.
package shop_pkg;

   localparam int CREDIT_W   = 10;
   localparam int ACTION_W   = 3;
   localparam int CREDIT_MAX = 1023;

   localparam logic [1:0] RES_OK      = 2'd0;
   localparam logic [1:0] RES_INVALID = 2'd1;
   localparam logic [1:0] RES_CREDIT  = 2'd2;
   localparam logic [1:0] RES_STOCK   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } wallet_state_t;

   // 11-bit add, clamped to the largest credit value
   function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? CREDIT_W'(CREDIT_MAX) : sum[CREDIT_W-1:0];
   endfunction

endpackage

// File: rtl/shop_wallet_ctrl_if.sv
// Wallet controller <-> shop stage bus. The controller is the master.
interface shop_wallet_ctrl_if;
   import shop_pkg::*;

   logic                buy_valid;
   logic [ACTION_W-1:0] action_number;
   logic [CREDIT_W-1:0] credit_in;
   logic                purchase_success;
   logic                err_invalid_action;
   logic                err_credit;
   logic                err_out_of_stock;
   logic [CREDIT_W-1:0] credit_out;

   modport master (
      output buy_valid, action_number, credit_in,
      input  purchase_success, err_invalid_action, err_credit, err_out_of_stock, credit_out
   );

   modport slave (
      input  buy_valid, action_number, credit_in,
      output purchase_success, err_invalid_action, err_credit, err_out_of_stock, credit_out
   );

endinterface

// File: rtl/shop_req_fifo.sv
// Buy-request FIFO: FIFO_DEPTH entries of one action number each.
// Supports push and pop in the same cycle; the owner never pushes when full
// or pops when empty.
module shop_req_fifo
   import shop_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [ACTION_W-1:0]         push_data,
   input  logic                        pop,
   output logic [ACTION_W-1:0]         head,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [ACTION_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;

   // pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/shop_wallet_ctrl.sv
// Wallet controller in front of the shop stage: queues buy requests, issues
// them one at a time, writes the shop's returned credit back and merges
// earned credit with saturation.
// Optional: define WALLET_STATS_EN to add success_cnt / fail_cnt outputs.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | flush earn_pending into wallet; pop next request if any
// ST_ISSUE  | buy_valid high; wallet frozen; shop flags captured
// ST_SETTLE | wallet <= credit_out + earn_pending; result pulse next cycle
module shop_wallet_ctrl
   import shop_pkg::*;
#(
   parameter int                  FIFO_DEPTH  = 4,
   parameter logic [CREDIT_W-1:0] INIT_CREDIT = 10'd200
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [ACTION_W-1:0]         req_action,
   input  logic                        earn_valid,
   input  logic [CREDIT_W-1:0]         earn_amount,
   shop_wallet_ctrl_if.master          shop,
   output logic [CREDIT_W-1:0]         wallet,
   output logic                        result_valid,
   output logic [1:0]                  result_code,
   output logic [ACTION_W-1:0]         result_action,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef WALLET_STATS_EN
   ,
   output logic [7:0]                  success_cnt,
   output logic [7:0]                  fail_cnt
`endif
);

   localparam int                   CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   wallet_state_t       state;
   wallet_state_t       state_nxt;
   logic [CREDIT_W-1:0] earn_pending;
   logic                push;
   logic                pop;
   logic [ACTION_W-1:0] fifo_head;
   logic [1:0]          flag_code;

   assign req_ready      = (fifo_count < DEPTH_CNT);
   assign push           = req_valid && req_ready;
   assign pop            = (state == ST_IDLE) && (fifo_count != '0);
   assign shop.credit_in = wallet;

   shop_req_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (req_action),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state; buy_valid is high for the single ISSUE cycle
   always_comb begin
      state_nxt      = state;
      shop.buy_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fifo_count != '0) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            shop.buy_valid = 1'b1;
            state_nxt      = ST_SETTLE;
         end
         ST_SETTLE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // shop flag priority: success > invalid > credit > stock, none reads as OK
   always_comb begin
      flag_code = RES_OK;
      if (shop.purchase_success) begin
         flag_code = RES_OK;
      end else if (shop.err_invalid_action) begin
         flag_code = RES_INVALID;
      end else if (shop.err_credit) begin
         flag_code = RES_CREDIT;
      end else if (shop.err_out_of_stock) begin
         flag_code = RES_STOCK;
      end
   end

   // wallet, earn accumulator, issued action and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wallet             <= INIT_CREDIT;
         earn_pending       <= '0;
         shop.action_number <= '0;
         result_valid       <= 1'b0;
         result_code        <= RES_OK;
         result_action      <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // an earn arriving in a flush cycle becomes the new pending value
               wallet       <= sat_add(wallet, earn_pending);
               earn_pending <= earn_valid ? earn_amount : '0;
               if (pop) begin
                  shop.action_number <= fifo_head;
               end
            end
            ST_ISSUE: begin
               result_code <= flag_code;
               if (earn_valid) begin
                  earn_pending <= sat_add(earn_pending, earn_amount);
               end
            end
            ST_SETTLE: begin
               // credit_out equals credit_in on a failed purchase
               wallet        <= sat_add(shop.credit_out, earn_pending);
               earn_pending  <= earn_valid ? earn_amount : '0;
               result_valid  <= 1'b1;
               result_action <= shop.action_number;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef WALLET_STATS_EN
   // saturating outcome counters
   always_ff @(posedge clk) begin
      if (rst) begin
         success_cnt <= '0;
         fail_cnt    <= '0;
      end else if (result_valid) begin
         if (result_code == RES_OK) begin
            if (success_cnt != 8'hFF) begin
               success_cnt <= success_cnt + 1'b1;
            end
         end else if (fail_cnt != 8'hFF) begin
            fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
